// File: rtl/seq_mult_unit.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_unit
// Purpose  : Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH bits.
//            Retires one multiplier bit per clock. Supports unsigned and
//            two's-complement operands, selected per transaction.
//            Valid/ready handshakes on both the operand and result sides.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            in_valid/ready  - operand handshake (ready only in IDLE)
//            a, b            - multiplicand / multiplier, WIDTH bits
//            is_signed       - 1: operands are two's complement
//            out_valid/ready - result handshake (valid only in DONE)
//            product         - 2*WIDTH-bit result, held while in DONE
//            busy            - high while a transaction is in flight
// Revision : 1.0 - initial release
// ============================================================================
module seq_mult_unit #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]      c_LAST    = CW'(WIDTH - 1);
    localparam logic [CW-1:0]      c_CNT_ONE = CW'(1);
    localparam logic [WIDTH-1:0]   c_ONE_W   = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] c_ONE_P   = (2*WIDTH)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        count_q, count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    // Magnitudes fit in WIDTH unsigned bits: -2^(WIDTH-1) negates to
    // 2^(WIDTH-1), which is representable as an unsigned WIDTH-bit value.
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_acc_sum;

    assign w_a_mag = (is_signed && a[WIDTH-1]) ? (~a + c_ONE_W) : a;
    assign w_b_mag = (is_signed && b[WIDTH-1]) ? (~b + c_ONE_W) : b;

    assign w_addend  = {{WIDTH{1'b0}}, mcand_q} << count_q;
    assign w_acc_sum = acc_q + (mplier_q[count_q] ? w_addend : '0);

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        neg_d     = neg_q;
        acc_d     = acc_q;
        count_d   = count_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = BUSY;
                    mcand_d  = w_a_mag;
                    mplier_d = w_b_mag;
                    neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d    = '0;
                    count_d  = '0;
                end
            end
            BUSY: begin
                acc_d   = w_acc_sum;
                count_d = count_q + c_CNT_ONE;
                if (count_q == c_LAST) begin
                    state_d   = DONE;
                    // Sign is applied once, to the final sum of this cycle.
                    product_d = neg_q ? (~w_acc_sum + c_ONE_P) : w_acc_sum;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            neg_q     <= neg_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    // Handshake outputs decode only the state register.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = product_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mult_unit
// Purpose  : Directed self-checking bench for seq_mult_unit at WIDTH=4.
//            Covers reset state, unsigned/signed corners, latency,
//            backpressure, busy-time input noise and mid-operation reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mult_unit;

    localparam int WIDTH = 4;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               is_signed;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic               busy;

    int n_checks;
    int n_errors;

    seq_mult_unit #(.WIDTH(WIDTH)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for in_ready, then present one transaction.
    task automatic accept(input logic [3:0] ta, input logic [3:0] tb_v,
                          input logic ts, input string tag);
        int budget;
        budget = 0;
        while (in_ready !== 1'b1 && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        check({tag, "_ready_wait"}, {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb_v;
        is_signed = ts;
        @(posedge clk); #1;   // acceptance edge E0
        in_valid  = 1'b0;
    endtask

    // Full transaction: latency, result, optional backpressure, handoff.
    task automatic do_txn(input logic [3:0] ta, input logic [3:0] tb_v,
                          input logic ts, input logic [7:0] exp,
                          input int hold, input bit noise, input string tag);
        out_ready = (hold == 0);
        accept(ta, tb_v, ts, tag);
        for (int i = 0; i < WIDTH - 1; i++) begin
            check({tag, "_busy_valid"}, {30'd0, out_valid, in_ready}, 32'd0);
            if (noise) begin
                in_valid  = 1'b1;
                a         = 4'($urandom);
                b         = 4'($urandom);
                is_signed = ~is_signed;
            end
            @(posedge clk); #1;
        end
        check({tag, "_pre_done"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;   // E0 + WIDTH
        in_valid = 1'b0;
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_product"}, {24'd0, product}, {24'd0, exp});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, {30'd0, out_valid, in_ready}, 32'd2);
            check({tag, "_hold_prod"}, {24'd0, product}, {24'd0, exp});
            if (i == hold - 1) out_ready = 1'b1;
        end
        @(posedge clk); #1;   // transfer edge
        check({tag, "_after_xfer"}, {29'd0, out_valid, in_ready, busy}, 32'd2);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        is_signed = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state: in_ready=1, out_valid=0, busy=0, product=0
        check("reset_ctrl", {29'd0, in_ready, out_valid, busy}, 32'd4);
        check("reset_prod", {24'd0, product}, 32'd0);

        do_txn(4'hF, 4'hF, 1'b0, 8'hE1, 0, 1'b0, "u_15x15");
        do_txn(4'h8, 4'h8, 1'b1, 8'h40, 0, 1'b0, "s_m8xm8");
        do_txn(4'h8, 4'h7, 1'b1, 8'hC8, 0, 1'b0, "s_m8x7");
        do_txn(4'hF, 4'h1, 1'b1, 8'hFF, 0, 1'b0, "s_m1x1");
        do_txn(4'h0, 4'hF, 1'b0, 8'h00, 0, 1'b0, "u_0x15");
        do_txn(4'h0, 4'hF, 1'b1, 8'h00, 0, 1'b0, "s_0xm1");
        do_txn(4'h3, 4'h5, 1'b0, 8'h0F, 0, 1'b0, "u_3x5");
        do_txn(4'h3, 4'h5, 1'b1, 8'h0F, 0, 1'b0, "s_3x5");
        do_txn(4'h6, 4'h7, 1'b0, 8'h2A, 4, 1'b0, "bp_6x7");
        do_txn(4'h9, 4'h9, 1'b0, 8'h51, 0, 1'b1, "noise_9x9");

        // Reset two cycles after acceptance
        out_ready = 1'b1;
        accept(4'h5, 4'h5, 1'b0, "rst_mid");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_ctrl", {29'd0, in_ready, out_valid, busy}, 32'd4);
        check("rst_mid_prod", {24'd0, product}, 32'd0);
        do_txn(4'h2, 4'h3, 1'b0, 8'h06, 0, 1'b0, "post_rst_2x3");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
